// File: rtl/rr_arbiter_4way_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_4way_if
// Description : Request/grant bundle between four requesters and the
//               round-robin arbiter guarding one shared resource.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_arbiter_4way_if;
    logic [3:0] req;        // level request, one bit per requester
    logic       done;       // current owner has finished
    logic [3:0] grant;      // one-hot grant, all zero when idle
    logic [1:0] grant_idx;  // index of current or last owner
    logic       busy;       // a grant is active
    logic       timeout;    // one-cycle pulse on forced release

    // Requester side: drives requests and completion, observes the grant.
    modport master (
        output req,
        output done,
        input  grant,
        input  grant_idx,
        input  busy,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_idx,
        output busy,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter_4way.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_4way
// Description : Four-way round-robin arbiter with hold-time limit and
//               done-handshake release. The winner is kept as a 2-bit index
//               and decoded to a registered one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_4way #(
    parameter int MAX_HOLD = 8,   // cycles a grant may stay asserted (1..255)
    parameter int CNT_W    = 8    // hold counter width, 2**CNT_W > MAX_HOLD
) (
    input  wire                 clk,
    input  wire                 rst_n,
    rr_arbiter_4way_if.slave    bus
);

    localparam logic [0:0]       S_IDLE      = 1'b0;
    localparam logic [0:0]       S_GRANT     = 1'b1;
    localparam logic [CNT_W-1:0] c_max_hold  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    logic [0:0]       r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_grant_idx;
    logic             r_busy;
    logic [3:0]       r_grant;
    logic             r_timeout;

    logic [7:0]       w_req_dbl;
    logic [3:0]       w_rot;
    logic [1:0]       w_offset;
    logic [1:0]       w_winner;
    logic [3:0]       w_winner_onehot;
    logic             w_rel_done;
    logic             w_rel_withdraw;
    logic             w_rel_max;
    logic             w_release;

    // Rotating the doubled request vector by ptr puts the highest-priority
    // requester at bit 0, so a fixed priority encoder yields the fair winner.
    assign w_req_dbl = {bus.req, bus.req};

    // Find the first requester at or after ptr in circular order.
    always_comb begin
        w_rot    = w_req_dbl[r_ptr +: 4];
        w_offset = 2'd0;
        if (w_rot[0])      w_offset = 2'd0;
        else if (w_rot[1]) w_offset = 2'd1;
        else if (w_rot[2]) w_offset = 2'd2;
        else               w_offset = 2'd3;
    end

    assign w_winner        = r_ptr + w_offset;
    assign w_winner_onehot = 4'b0001 << w_winner;

    // Release causes while a grant is held; only the owner's req bit matters.
    assign w_rel_done     = bus.done;
    assign w_rel_withdraw = ~bus.req[r_grant_idx];
    assign w_rel_max      = (r_cnt == c_max_hold);
    assign w_release      = w_rel_done | w_rel_withdraw | w_rel_max;

    // Two-state arbitration FSM with registered grant, index, busy and timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'd0;
            r_cnt       <= '0;
            r_grant_idx <= 2'd0;
            r_busy      <= 1'b0;
            r_grant     <= 4'b0000;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // done is meaningless here; only requests start a grant.
                    if (|bus.req) begin
                        r_state     <= S_GRANT;
                        r_grant_idx <= w_winner;
                        r_grant     <= w_winner_onehot;
                        r_busy      <= 1'b1;
                        r_cnt       <= c_cnt_one;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        // Always pass through IDLE so owners never abut.
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_grant   <= 4'b0000;
                        r_cnt     <= '0;
                        r_ptr     <= r_grant_idx + 2'd1;
                        r_timeout <= w_rel_max & ~w_rel_done & ~w_rel_withdraw;
                    end else if (r_cnt != c_max_hold) begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_grant <= 4'b0000;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.grant_idx = r_grant_idx;
    assign bus.busy      = r_busy;
    assign bus.timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4way.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_4way
// Description : Self-checking bench for rr_arbiter_4way: directed scenarios
//               plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_4way;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 8;

    logic clk;
    logic rst_n;

    rr_arbiter_4way_if bus();

    rr_arbiter_4way #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: who owns the resource, for how many cycles, and
    // where the next fair search starts.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_timeout;

    function automatic void model_reset();
        m_busy    = 0;
        m_owner   = 0;
        m_ptr     = 0;
        m_held    = 0;
        m_timeout = 0;
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic d);
        bit by_done, by_withdraw, by_limit;
        if (!m_busy) begin
            m_timeout = 0;
            if (r != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    if (r[(m_ptr + k) % 4]) begin
                        m_owner = (m_ptr + k) % 4;
                        break;
                    end
                end
                m_busy = 1;
                m_held = 1;
            end
        end else begin
            by_done     = d;
            by_withdraw = !r[m_owner];
            by_limit    = (m_held >= MAX_HOLD);
            if (by_done || by_withdraw || by_limit) begin
                m_busy    = 0;
                m_held    = 0;
                m_ptr     = (m_owner + 1) % 4;
                m_timeout = by_limit && !by_done && !by_withdraw;
            end else begin
                m_held    = m_held + 1;
                m_timeout = 0;
            end
        end
    endfunction

    function automatic logic [3:0] exp_grant();
        logic [3:0] one;
        one = 4'b0001;
        return m_busy ? (one << m_owner) : 4'b0000;
    endfunction

    // Apply inputs, clock once, advance the model, sample 1ns after the edge.
    task automatic tick(input logic [3:0] r, input logic d);
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.timeout !== 1'b0 || bus.grant_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: grant=%b busy=%b timeout=%b idx=%0d, required 0000/0/0/0",
                     bus.grant, bus.busy, bus.timeout, bus.grant_idx);
        end
    endtask

    task automatic test_single_done();
        do_reset();
        tick(4'b0001, 1'b0);
        n_checks++;
        if (bus.grant !== 4'b0001 || bus.grant_idx !== 2'd0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: grant=%b idx=%0d busy=%b, required 0001/0/1",
                     bus.grant, bus.grant_idx, bus.busy);
        end
        tick(4'b0001, 1'b1);
        n_checks++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done_release: grant=%b busy=%b timeout=%b, required 0000/0/0",
                     bus.grant, bus.busy, bus.timeout);
        end
        // ptr must now be 1: requester 1 beats requester 0.
        tick(4'b1111, 1'b0);
        n_checks++;
        if (bus.grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL single_ptr_advance: grant=%b, required 0010", bus.grant);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(4'b1111, 1'b0);
            n_checks++;
            if (bus.grant !== seq[i]) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: grant=%b, required %b", i, bus.grant, seq[i]);
            end
            tick(4'b1111, 1'b1);
            n_checks++;
            if (bus.grant !== 4'b0000) begin
                n_fail++;
                $display("FAIL rr_gap_%0d: grant=%b, required 0000", i, bus.grant);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 1; c <= MAX_HOLD; c++) begin
            tick(4'b0100, 1'b0);
            n_checks++;
            if (bus.grant !== 4'b0100 || bus.timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_hold_cycle_%0d: grant=%b timeout=%b, required 0100/0",
                         c, bus.grant, bus.timeout);
            end
        end
        tick(4'b0100, 1'b0);
        n_checks++;
        if (bus.grant !== 4'b0000 || bus.timeout !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_release: grant=%b timeout=%b busy=%b, required 0000/1/0",
                     bus.grant, bus.timeout, bus.busy);
        end
        // ptr is now 3, and the pulse must be gone.
        tick(4'b1111, 1'b0);
        n_checks++;
        if (bus.grant !== 4'b1000 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_after: grant=%b timeout=%b, required 1000/0",
                     bus.grant, bus.timeout);
        end
    endtask

    task automatic test_done_at_max();
        do_reset();
        for (int c = 1; c <= MAX_HOLD; c++) tick(4'b0100, 1'b0);
        tick(4'b0100, 1'b1);
        n_checks++;
        if (bus.grant !== 4'b0000 || bus.timeout !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_at_max: grant=%b timeout=%b busy=%b, required 0000/0/0",
                     bus.grant, bus.timeout, bus.busy);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        tick(4'b0010, 1'b0);
        // Non-owner bits toggling must not disturb the grant.
        tick(4'b1110, 1'b0);
        n_checks++;
        if (bus.grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL withdraw_nonowner: grant=%b, required 0010", bus.grant);
        end
        tick(4'b1100, 1'b0);
        n_checks++;
        if (bus.grant !== 4'b0000 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL withdraw_release: grant=%b timeout=%b, required 0000/0",
                     bus.grant, bus.timeout);
        end
        tick(4'b1111, 1'b0);
        n_checks++;
        if (bus.grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL withdraw_ptr: grant=%b, required 0100", bus.grant);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(4'b0001, 1'b0);
        tick(4'b0001, 1'b1);
        tick(4'b0010, 1'b0);
        n_checks++;
        if (bus.grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL async_setup: grant=%b, required 0010", bus.grant);
        end
        // Assert reset between edges; outputs must clear without a clock.
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_drop: grant=%b busy=%b, required 0000/0", bus.grant, bus.busy);
        end
        #2;
        rst_n = 1'b1;
        tick(4'b1010, 1'b0);
        n_checks++;
        if (bus.grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL async_ptr_cleared: grant=%b, required 0010", bus.grant);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       d;
        logic [3:0] eg;
        do_reset();
        r = 4'b0000;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 6) == 0);
            tick(r, d);
            eg = exp_grant();
            n_checks++;
            if (bus.grant !== eg) begin
                n_fail++;
                $display("FAIL rand_grant cyc=%0d: grant=%b, required %b", cyc, bus.grant, eg);
            end
            n_checks++;
            if (bus.busy !== m_busy) begin
                n_fail++;
                $display("FAIL rand_busy cyc=%0d: busy=%b, required %b", cyc, bus.busy, m_busy);
            end
            n_checks++;
            if (bus.timeout !== m_timeout) begin
                n_fail++;
                $display("FAIL rand_timeout cyc=%0d: timeout=%b, required %b", cyc, bus.timeout, m_timeout);
            end
            n_checks++;
            if (bus.grant_idx !== 2'(m_owner)) begin
                n_fail++;
                $display("FAIL rand_idx cyc=%0d: idx=%0d, required %0d", cyc, bus.grant_idx, m_owner);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        model_reset();
        test_reset();
        test_single_done();
        test_round_robin();
        test_timeout();
        test_done_at_max();
        test_withdraw();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
